gcd_operand_bank: RTL and testbench

- Parametrised successor to the fixed-width GCD SRAM unpacker.
- Maps an SRAM-style 64-bit slave port onto N_ARG wide argument registers and N_RES wide result snapshot registers, with byte-enabled partial writes.
- Adds a control/status register, START/DONE handshake with BUSY tracking, coherent result capture, an error flag and an interrupt level.
- Sits between the AXI-to-SRAM bridge and one GCD-class compute core.

---
 rtl/gcd_operand_bank.sv | 153 +++++++++++++++
 tb/tb_gcd_operand_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_bank.sv
// SRAM-port operand bank for a GCD-class core: argument registers, result
// snapshots, CTRL/STATUS with START/DONE handshake, error flag and IRQ level.

// One operand register with windowed 64-bit word access. Arguments use the
// byte-enabled word write path; result snapshots use the whole-vector load.
module gcd_operand_reg #(
  parameter int W     = 1279,
  parameter int WORDS = 20,
  parameter int BASE  = 'h200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   word,
  input  logic          wr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wbe,
  input  logic          ld,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  q,
  output logic          hit,
  output logic [63:0]   rd
);
  localparam logic [10:0] LO = 11'(BASE);
  localparam logic [10:0] HI = 11'(BASE + WORDS);
  localparam int          PW = (WORDS + 1) * 64 - W;

  logic [10:0]             off;
  logic [(WORDS+1)*64-1:0] padded;

  assign hit    = (word >= LO) && (word < HI);
  assign off    = word - LO;
  // Bits above W read back as zero through the zero-padded view.
  assign padded = {{PW{1'b0}}, q};
  assign rd     = hit ? padded[{off, 6'b0} +: 64] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else if (wr && hit) begin
      for (int p = 0; p < W; p++) begin
        if (off == 11'(p / 64) && wbe[(p % 64) / 8])
          q[p] <= wdata[p % 64];
      end
    end
  end
endmodule

module gcd_operand_bank #(
  parameter int ARG_W   = 1279,
  parameter int RES_W   = 1284,
  parameter int N_ARG   = 2,
  parameter int N_RES   = 2,
  parameter int WSTRIDE = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SRAM_CEn,
  input  logic [31:0]            SRAM_ADDR,
  input  logic [63:0]            SRAM_WDATA,
  input  logic                   SRAM_WEn,
  input  logic [7:0]             SRAM_WBEn,
  output logic [63:0]            SRAM_RDATA,
  output logic                   START,
  input  logic                   DONE,
  output logic [N_ARG*ARG_W-1:0] ARG,
  input  logic [N_RES*RES_W-1:0] RESULT,
  output logic                   BUSY,
  output logic                   IRQ
);
  localparam int ARG_WORDS = (ARG_W + 63) / 64;
  localparam int RES_WORDS = (RES_W + 63) / 64;
  localparam logic [63:0] INFO = {16'b0, 8'(N_RES), 8'(N_ARG), 16'(RES_W), 16'(ARG_W)};

  logic [10:0] word;
  logic        wr_cyc, rd_cyc, ctrl_wr, start_req, clr_req, done_ev;
  logic        arg_wr, arg_wr_err, err_set;
  logic        done_flag, err;
  logic [7:0]  wbe;
  logic [63:0] rd_word;
  logic        unused_addr;

  logic [N_ARG-1:0][ARG_W-1:0] arg_q;
  logic [N_ARG-1:0][63:0]      arg_rd;
  logic [N_ARG-1:0]            arg_hit;
  logic [N_RES-1:0][RES_W-1:0] res_q;
  logic [N_RES-1:0][63:0]      res_rd;
  logic [N_RES-1:0]            res_hit;

  assign word        = SRAM_ADDR[13:3];
  assign unused_addr = ^{SRAM_ADDR[31:14], SRAM_ADDR[2:0], res_hit};
  assign wbe         = ~SRAM_WBEn;
  assign wr_cyc      = !SRAM_CEn && !SRAM_WEn;
  assign rd_cyc      = !SRAM_CEn &&  SRAM_WEn;

  assign ctrl_wr    = wr_cyc && (word == 11'd0) && wbe[0];
  assign start_req  = ctrl_wr && SRAM_WDATA[0];
  assign clr_req    = ctrl_wr && SRAM_WDATA[1];
  assign done_ev    = DONE && BUSY;
  // Arguments are frozen while an operation is in flight.
  assign arg_wr     = wr_cyc && !BUSY;
  assign arg_wr_err = wr_cyc && BUSY && (|arg_hit);
  assign err_set    = (start_req && BUSY) || arg_wr_err;
  assign IRQ        = done_flag;

  for (genvar i = 0; i < N_ARG; i++) begin : g_arg
    gcd_operand_reg #(.W(ARG_W), .WORDS(ARG_WORDS), .BASE('h200 + i * WSTRIDE)) u_arg (
      .clk(CLK), .rst(RESET), .word(word), .wr(arg_wr), .wdata(SRAM_WDATA), .wbe(wbe),
      .ld(1'b0), .ld_data('0), .q(arg_q[i]), .hit(arg_hit[i]), .rd(arg_rd[i])
    );
    assign ARG[i*ARG_W +: ARG_W] = arg_q[i];
  end

  for (genvar j = 0; j < N_RES; j++) begin : g_res
    gcd_operand_reg #(.W(RES_W), .WORDS(RES_WORDS), .BASE('h400 + j * WSTRIDE)) u_res (
      .clk(CLK), .rst(RESET), .word(word), .wr(1'b0), .wdata(SRAM_WDATA), .wbe(wbe),
      .ld(done_ev), .ld_data(RESULT[j*RES_W +: RES_W]), .q(res_q[j]), .hit(res_hit[j]),
      .rd(res_rd[j])
    );
  end

  always_comb begin
    rd_word = '0;
    if (word == 11'd0) begin
      rd_word = {61'b0, err, done_flag, BUSY};
    end else if (word == 11'd1) begin
      rd_word = INFO;
    end else begin
      for (int i = 0; i < N_ARG; i++) rd_word = rd_word | arg_rd[i];
      for (int j = 0; j < N_RES; j++) rd_word = rd_word | res_rd[j];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SRAM_RDATA <= '0;
      START      <= 1'b0;
      BUSY       <= 1'b0;
      done_flag  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (rd_cyc) SRAM_RDATA <= rd_word;
      START <= start_req && !BUSY;
      BUSY  <= (BUSY && !done_ev) || (start_req && !BUSY);
      // Set beats clear when both land in the same cycle.
      if (done_ev)      done_flag <= 1'b1;
      else if (clr_req) done_flag <= 1'b0;
      if (err_set)      err <= 1'b1;
      else if (clr_req) err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gcd_operand_bank.sv
// Directed bench for gcd_operand_bank: vector table for address/byte-enable
// behaviour, hand sequences for the START/DONE handshake and reset.
module tb_gcd_operand_bank;
  localparam int ARG_W = 1279, RES_W = 1284, N_ARG = 2, N_RES = 2;
  localparam logic [63:0] INFO = 64'h0000_0202_0504_04FF;

  logic                   clk = 0, rst = 1, cen = 1, wen = 1, done = 0;
  logic [31:0]            addr = 0;
  logic [63:0]            wdata = 0, rdata;
  logic [7:0]             wben = 8'hFF;
  logic                   start, busy, irq;
  logic [N_ARG*ARG_W-1:0] arg;
  logic [N_RES*RES_W-1:0] result = '0;
  logic [63:0]            d;
  int                     tests = 0, fails = 0;

  gcd_operand_bank dut (
    .CLK(clk), .RESET(rst), .SRAM_CEn(cen), .SRAM_ADDR(addr), .SRAM_WDATA(wdata),
    .SRAM_WEn(wen), .SRAM_WBEn(wben), .SRAM_RDATA(rdata), .START(start), .DONE(done),
    .ARG(arg), .RESULT(result), .BUSY(busy), .IRQ(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wa;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [31:0] ra;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] dd, input logic [7:0] be);
    @(negedge clk); cen = 0; wen = 0; addr = a; wdata = dd; wben = be;
    @(posedge clk); #1; cen = 1; wen = 1; wben = 8'hFF;
  endtask

  task automatic rd(input logic [31:0] a, output logic [63:0] dd);
    @(negedge clk); cen = 0; wen = 1; addr = a;
    @(posedge clk); #1; cen = 1; dd = rdata;
  endtask

  task automatic pulse_done();
    @(negedge clk); done = 1;
    @(posedge clk); #1; done = 0;
  endtask

  initial begin
    vecs[0] = '{32'h1098, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h1098, 64'h7FFF_FFFF_FFFF_FFFF};
    vecs[1] = '{32'h1100, 64'h1122_3344_5566_7788, 8'hF0, 32'h1100, 64'h0000_0000_5566_7788};
    vecs[2] = '{32'h1000, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 32'h5004, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3] = '{32'h10A0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h10A0, 64'h0};
    vecs[4] = '{32'h0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h0008, INFO};
    vecs[5] = '{32'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h2000, 64'h0};
    vecs[6] = '{32'h1008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h7E, 32'h1008, 64'hAA00_0000_0000_00AA};
    vecs[7] = '{32'h1200, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 32'h1200, 64'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 64'(start), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_arg", 64'(|arg), 64'h0);
    @(negedge clk); rst = 0;
    rd(32'h0, d); check("status_reset", d, 64'h0);
    rd(32'h8, d); check("info", d, INFO);

    // Address map, byte enables, top-word truncation, read-only spaces
    foreach (vecs[n]) begin
      wr(vecs[n].wa, vecs[n].wd, vecs[n].be);
      rd(vecs[n].ra, d);
      check($sformatf("vec%0d", n), d, vecs[n].exp);
    end
    check("arg0_top", 64'(arg[1278:1216]), 64'h7FFF_FFFF_FFFF_FFFF);
    check("arg0_w0", arg[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    check("arg1_w0", arg[ARG_W +: 64], 64'h0000_0000_5566_7788);
    rd(32'h1100, d); wr(32'h0, 64'h0, 8'hFF); check("rdata_hold", rdata, 64'h0000_0000_5566_7788);

    // Start handshake and busy protection
    wr(32'h0, 64'h1, 8'hFE);
    check("start_pulse", 64'(start), 64'h1);
    check("busy_set", 64'(busy), 64'h1);
    @(posedge clk); #1;
    check("start_one_cycle", 64'(start), 64'h0);
    wr(32'h0, 64'h1, 8'hFE);
    check("no_restart", 64'(start), 64'h0);
    rd(32'h0, d); check("status_err_busy", d, 64'h5);
    wr(32'h1100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(32'h1100, d); check("arg_frozen", d, 64'h0000_0000_5566_7788);

    // Completion and result capture
    result[15:0] = 16'hABCD;
    result[1283:1280] = 4'hF;
    result[RES_W +: 16] = 16'h1234;
    pulse_done();
    check("done_busy", 64'(busy), 64'h0);
    check("done_irq", 64'(irq), 64'h1);
    result = '0;
    rd(32'h2000, d); check("res0_w0", d, 64'hABCD);
    rd(32'h20A0, d); check("res0_top", d, 64'hF);
    rd(32'h2100, d); check("res1_w0", d, 64'h1234);
    rd(32'h0, d); check("status_done_err", d, 64'h6);
    wr(32'h0, 64'h2, 8'hFE);
    rd(32'h0, d); check("status_clear", d, 64'h0);
    check("irq_clear", 64'(irq), 64'h0);

    // DONE in the same cycle as a start write
    wr(32'h0, 64'h1, 8'hFE);
    result[15:0] = 16'h5555;
    @(negedge clk); cen = 0; wen = 0; addr = 0; wdata = 64'h1; wben = 8'hFE; done = 1;
    @(posedge clk); #1; cen = 1; wen = 1; wben = 8'hFF; done = 0;
    check("sim_no_start", 64'(start), 64'h0);
    rd(32'h0, d); check("sim_status", d, 64'h6);
    rd(32'h2000, d); check("sim_capture", d, 64'h5555);

    // DONE while idle is ignored
    wr(32'h0, 64'h2, 8'hFE);
    result[15:0] = 16'h9999;
    pulse_done();
    rd(32'h0, d); check("idle_done_status", d, 64'h0);
    rd(32'h2000, d); check("idle_done_snap", d, 64'h5555);

    // Flag set beats clear; start+clear while busy still flags the error
    wr(32'h0, 64'h1, 8'hFE);
    @(negedge clk); cen = 0; wen = 0; addr = 0; wdata = 64'h3; wben = 8'hFE; done = 1;
    @(posedge clk); #1; cen = 1; wen = 1; wben = 8'hFF; done = 0;
    rd(32'h0, d); check("set_wins", d, 64'h6);
    wr(32'h0, 64'h2, 8'hFE);
    wr(32'h0, 64'h1, 8'hFE);
    @(negedge clk); cen = 0; wen = 0; addr = 0; wdata = 64'h2; wben = 8'hFE; done = 1;
    @(posedge clk); #1; cen = 1; wen = 1; wben = 8'hFF; done = 0;
    rd(32'h0, d); check("done_vs_clear", d, 64'h2);
    wr(32'h0, 64'h2, 8'hFE);

    // Asynchronous reset mid-operation
    wr(32'h0, 64'h1, 8'hFE);
    #2 rst = 1;
    #1;
    check("amid_busy", 64'(busy), 64'h0);
    check("amid_arg", 64'(|arg), 64'h0);
    check("amid_rdata", rdata, 64'h0);
    @(negedge clk); rst = 0;
    result[15:0] = 16'h7777;
    pulse_done();
    check("post_rst_irq", 64'(irq), 64'h0);
    rd(32'h2000, d); check("post_rst_snap", d, 64'h0);
    rd(32'h0, d); check("post_rst_status", d, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
